// File: rtl/bsg_activation_pack.sv
// rtl/bsg_activation_pack.sv - round/saturate activation results and pack them into lane vectors
module bsg_activation_pack #(
    parameter int in_width_p  = 32,
    parameter int in_frac_p   = 16,
    parameter int out_width_p = 8,
    parameter int out_frac_p  = 7,
    parameter int els_p       = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             v_i,
    input  logic [in_width_p-1:0]            data_i,
    input  logic                             last_i,
    output logic                             ready_o,
    output logic                             v_o,
    output logic [els_p*out_width_p-1:0]     data_o,
    output logic [$clog2(els_p+1)-1:0]       count_o,
    output logic                             sat_o,
    input  logic                             ready_i
);

    localparam int sh_lp    = in_frac_p - out_frac_p;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int vec_w_lp = els_p * out_width_p;

    // Rounding bias and clamp limits, held at the widened input precision.
    localparam logic signed [in_width_p:0] round_c = (in_width_p+1)'(1) << (sh_lp - 1);
    localparam logic signed [in_width_p:0] max_c   = (in_width_p+1)'((1 << (out_width_p - 1)) - 1);
    localparam logic signed [in_width_p:0] min_c   = (in_width_p+1)'(-(1 << (out_width_p - 1)));

    typedef enum logic {e_FILL, e_FULL} state_e;

    state_e                     state_r;
    logic [vec_w_lp-1:0]        acc_r;
    logic                       acc_sat_r;
    logic [cnt_w_lp-1:0]        idx_r;

    logic                       accept;
    logic                       deq;
    logic                       close;
    logic signed [in_width_p:0] ext;
    logic signed [in_width_p:0] sum;
    logic signed [in_width_p:0] shifted;
    logic [out_width_p-1:0]     lane;
    logic                       lane_sat;
    logic [vec_w_lp-1:0]        acc_n;

    // A held vector blocks input only while the consumer is stalling it.
    assign v_o     = (state_r == e_FULL);
    assign ready_o = (state_r == e_FILL) | ready_i;
    assign accept  = v_i & ready_o;
    assign deq     = v_o & ready_i;
    assign close   = last_i | (idx_r == cnt_w_lp'(els_p - 1));

    // Round half toward +inf with an arithmetic shift, then clamp to the lane range.
    always_comb begin
        ext      = {data_i[in_width_p-1], data_i};
        sum      = ext + round_c;
        shifted  = sum >>> sh_lp;
        lane     = shifted[out_width_p-1:0];
        lane_sat = 1'b0;
        if (shifted > max_c) begin
            lane     = max_c[out_width_p-1:0];
            lane_sat = 1'b1;
        end else if (shifted < min_c) begin
            lane     = min_c[out_width_p-1:0];
            lane_sat = 1'b1;
        end
    end

    // Drop the converted lane into the slot selected by the fill index; unused lanes stay zero.
    always_comb begin
        acc_n = acc_r;
        for (int i = 0; i < els_p; i++) begin
            if (idx_r == cnt_w_lp'(i)) begin
                acc_n[i*out_width_p +: out_width_p] = lane;
            end
        end
    end

    // Fill/emit state machine; the fill buffer is independent of the held output so a
    // dequeue and an accept can happen in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_FILL;
            acc_r     <= '0;
            acc_sat_r <= 1'b0;
            idx_r     <= '0;
            data_o    <= '0;
            count_o   <= '0;
            sat_o     <= 1'b0;
        end else begin
            if (accept && close) begin
                data_o    <= acc_n;
                count_o   <= idx_r + cnt_w_lp'(1);
                sat_o     <= acc_sat_r | lane_sat;
                acc_r     <= '0;
                acc_sat_r <= 1'b0;
                idx_r     <= '0;
                state_r   <= e_FULL;
            end else begin
                if (accept) begin
                    acc_r     <= acc_n;
                    acc_sat_r <= acc_sat_r | lane_sat;
                    idx_r     <= idx_r + cnt_w_lp'(1);
                end
                if (deq) begin
                    state_r <= e_FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_activation_pack.sv
// tb/tb_bsg_activation_pack.sv - randomized and directed bench with a behavioural packing model
module tb_bsg_activation_pack;

    localparam int IW  = 32;
    localparam int IF  = 16;
    localparam int OW  = 8;
    localparam int OF  = 7;
    localparam int ELS = 4;
    localparam int CW  = $clog2(ELS + 1);

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                v_i;
    logic [IW-1:0]       data_i;
    logic                last_i;
    logic                ready_o;
    logic                v_o;
    logic [ELS*OW-1:0]   data_o;
    logic [CW-1:0]       count_o;
    logic                sat_o;
    logic                ready_i;

    bsg_activation_pack #(
        .in_width_p(IW), .in_frac_p(IF), .out_width_p(OW), .out_frac_p(OF), .els_p(ELS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .count_o(count_o), .sat_o(sat_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ELS*OW-1:0] data;
        int                cnt;
        bit                sat;
    } vec_t;

    vec_t              expq[$];
    logic [ELS*OW-1:0] cur_data;
    int                cur_n;
    bit                cur_sat;

    vec_t              last_pop;
    int                pops;
    int                checks;
    int                errors;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Floor-division reference: value * 2^(OF-IF), nearest, ties up, then clamp.
    function automatic longint conv(input logic [IW-1:0] d, output bit s);
        longint x, v, q, div, lo, hi;
        x   = longint'($signed(d));
        div = longint'(1) << (IF - OF);
        v   = x + div / 2;
        if (v >= 0) q = v / div;
        else        q = -((-v + div - 1) / div);
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        s  = 1'b0;
        if (q > hi) begin q = hi; s = 1'b1; end
        if (q < lo) begin q = lo; s = 1'b1; end
        return q;
    endfunction

    task automatic model_clear();
        expq.delete();
        cur_data = '0;
        cur_n    = 0;
        cur_sat  = 1'b0;
    endtask

    // One clock: drive inputs, compare the settled outputs against the model, update the model.
    task automatic step(input logic v, input logic [IW-1:0] d, input logic l, input logic r);
        bit     acc, dq, s;
        longint q;
        vec_t   e, nv;
        v_i = v; data_i = d; last_i = l; ready_i = r;
        #1;
        chk("v_o_vs_model", v_o, (expq.size() != 0));
        chk("ready_o", ready_o, (expq.size() == 0) || r);
        acc = v && ((expq.size() == 0) || r);
        dq  = (expq.size() != 0) && r;
        if (dq) begin
            e = expq.pop_front();
            chk("vec_data", data_o, e.data);
            chk("vec_count", count_o, e.cnt);
            chk("vec_sat", sat_o, e.sat);
            last_pop = e;
            pops++;
        end
        if (acc) begin
            q = conv(d, s);
            cur_data[cur_n*OW +: OW] = q[OW-1:0];
            cur_sat = cur_sat | s;
            cur_n++;
            if (l || cur_n == ELS) begin
                nv.data = cur_data; nv.cnt = cur_n; nv.sat = cur_sat;
                expq.push_back(nv);
                cur_data = '0; cur_n = 0; cur_sat = 1'b0;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        v_i = $urandom_range(0, 1); data_i = $urandom; last_i = $urandom_range(0, 1); ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_clear();
        #1;
        chk("rst_v_o", v_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_count_o", count_o, 0);
        chk("rst_sat_o", sat_o, 0);
        ready_i = 1'b0;
        #1;
        chk("rst_ready_o", ready_o, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    logic [ELS*OW-1:0] held;
    int                p0;

    initial begin
        checks = 0; errors = 0; pops = 0;
        reset_i = 1'b1; v_i = 0; data_i = '0; last_i = 0; ready_i = 0;
        model_clear();
        @(negedge clk_i);
        do_reset();

        // Defaults: lanes 0x40, 0x7F (saturated), 0x80, 0x01.
        p0 = pops;
        step(1, 32'h00008000, 0, 1);
        step(1, 32'h00010000, 0, 1);
        step(1, 32'hFFFF0000, 0, 1);
        step(1, 32'h00000100, 0, 1);
        step(0, '0, 0, 1);
        chk("t1_popped", pops - p0, 1);
        chk("t1_data", last_pop.data, 32'h01807F40);
        chk("t1_count", last_pop.cnt, 4);
        chk("t1_sat", last_pop.sat, 1);

        // Rounding ties, closed early on the third element.
        p0 = pops;
        step(1, 32'hFFFFFF00, 0, 1);
        step(1, 32'h000000FF, 0, 1);
        step(1, 32'hFFFFFEFF, 1, 1);
        step(0, '0, 0, 1);
        chk("t2_popped", pops - p0, 1);
        chk("t2_data", last_pop.data, 32'h00FF0000);
        chk("t2_count", last_pop.cnt, 3);

        // Early close on the second element; v_o the cycle after the closing accept.
        step(1, 32'h00004000, 0, 0);
        step(1, 32'h00002000, 1, 0);
        #1;
        chk("t3_v_o", v_o, 1);
        chk("t3_data", data_o, 32'h00001020);
        chk("t3_count", count_o, 2);
        chk("t3_sat", sat_o, 0);
        drain();

        // Backpressure: full vector held for 5 cycles with input pending.
        for (int i = 0; i < ELS; i++) step(1, $urandom, 0, 0);
        #1;
        held = data_o;
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h00001234, 0, 0);
            chk("t4_hold_data", data_o, held);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, $urandom, 1, 1);
            chk("t4_no_bubble", v_o, 1);
        end
        drain();

        // Dequeue and single-element closing accept in the same cycle.
        step(1, 32'h00008000, 1, 0);
        step(1, 32'h00010000, 1, 1);
        #1;
        chk("t5_v_o", v_o, 1);
        chk("t5_count", count_o, 1);
        chk("t5_data", data_o, 32'h0000007F);
        chk("t5_sat", sat_o, 1);
        drain();

        // Reset mid-fill discards the partial vector.
        step(1, 32'h00000200, 0, 1);
        step(1, 32'h00000400, 0, 1);
        do_reset();
        step(0, '0, 0, 1);
        chk("t6_no_v_o", v_o, 0);
        p0 = pops;
        for (int i = 0; i < ELS; i++) step(1, 32'h00000200, 0, 1);
        step(0, '0, 0, 1);
        chk("t6_popped", pops - p0, 1);
        chk("t6_count", last_pop.cnt, 4);
        chk("t6_data", last_pop.data, 32'h01010101);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [IW-1:0] d;
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = IW'($signed($urandom_range(0, 1 << 18)) - (1 << 17));
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
            if (i == 1500) do_reset();
        end
        drain();
        chk("end_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
